// File: rtl/addr_seq_pkg.sv
// Shared types and default widths for the address sequencer.
package addr_seq_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int WIDTH_DEF = 8;
    localparam int LEN_W_DEF = 8;

endpackage

// File: rtl/addr_seq_cnt.sv
// Loadable down-counter tracking the beats left in the current burst pass.
module addr_seq_cnt
    import addr_seq_pkg::*;
#(
    parameter int W = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         is_one
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec)
            count <= count - ONE;
    end

    assign is_one = (count == ONE);

endmodule

// File: rtl/addr_seq_reg.sv
// Address register with legacy load/hold plus linear/circular burst sequencing
// over a valid/ready handshake. All outputs come straight from flops.
module addr_seq_reg
    import addr_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in_addr,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [LEN_W-1:0] len,
    input  logic             circ,
    input  logic             abort,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_addr,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ADDR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] base_q;
    logic [LEN_W-1:0] len_q;
    logic             circ_q;

    logic             go;
    logic             beat;
    logic             last;
    logic             cnt_load;
    logic             cnt_dec;
    logic [LEN_W-1:0] cnt_val;
    logic [LEN_W-1:0] remaining;
    logic             rem_one;

    // go: a burst is accepted from IDLE; beat: a non-aborted handshake in RUN
    assign go   = (state == IDLE) && start && (len != '0);
    assign beat = (state == RUN) && !abort && out_valid && out_ready;
    assign last = beat && rem_one;

    // A circular pass reloads the full length; a linear last beat just counts down to 0
    assign cnt_load = go || (last && circ_q);
    assign cnt_dec  = beat && !(rem_one && circ_q);
    assign cnt_val  = (state == IDLE) ? len : len_q;

    addr_seq_cnt #(.W(LEN_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .count    (remaining),
        .is_one   (rem_one)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            out_addr  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            circ_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            base_q    <= base;
                            len_q     <= len;
                            circ_q    <= circ;
                            out_addr  <= base;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (ld) begin
                        out_addr <= in_addr;
                    end
                end
                RUN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (beat) begin
                        if (!rem_one) begin
                            out_addr <= out_addr + ADDR_ONE;
                        end else if (circ_q) begin
                            out_addr <= base_q;
                            wrap     <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // remaining is only consumed through rem_one
    logic unused_rem;
    assign unused_rem = ^remaining;

endmodule

// File: doc/addr_seq_reg.md
# addr_seq_reg

Parametrised address register/sequencer, the next-generation replacement for the single 8-bit load/hold address register in the FIR datapath. It keeps the legacy load/hold behaviour and adds a burst mode that walks an address range (linear or circular) with a valid/ready handshake. It sits between the FIR control unit and the sample/coefficient memories and supplies one address per accepted beat.

## Interface
- WIDTH, 8, address width in bits
- LEN_W, 8, burst length counter width in bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- ld  in  1  legacy load: out_addr <= in_addr (IDLE only)
- in_addr  in  WIDTH  legacy load value
- start  in  1  begin burst (IDLE only)
- base  in  WIDTH  first address of burst, sampled on start
- len  in  LEN_W  beats per pass, sampled on start
- circ  in  1  1 = circular (repeat pass until abort), sampled on start
- abort  in  1  terminate burst (RUN only)
- out_ready  in  1  consumer accepts out_addr this cycle
- out_addr  out  WIDTH  current address
- out_valid  out  1  out_addr is a burst beat
- busy  out  1  state == RUN
- done  out  1  one-cycle pulse after last beat of a linear burst
- wrap  out  1  one-cycle pulse when a circular burst restarts at base

## Operation
- States: IDLE, RUN. Reset (rst=0 at a clock edge): state IDLE, out_addr 0, out_valid 0, busy 0, done 0, wrap 0, internal base/len/remaining 0. Reset mid-burst aborts immediately, no done.
- IDLE, priority start > ld:
  - start=1, len!=0: latch base/len/circ; out_addr <= base, remaining <= len, out_valid <= 1, -> RUN.
  - start=1, len==0: done <= 1 next cycle, stay IDLE, out_addr unchanged.
  - ld=1 (no start): out_addr <= in_addr; out_valid stays 0.
  - else out_addr holds.
- RUN, priority abort > handshake; start and ld ignored:
  - abort=1: -> IDLE, out_valid <= 0, no done, out_addr holds.
  - handshake (out_valid & out_ready), remaining>1: out_addr <= out_addr+1 (mod 2^WIDTH), remaining--.
  - handshake, remaining==1, circ=0: -> IDLE, out_valid <= 0, done <= 1, out_addr holds last beat.
  - handshake, remaining==1, circ=1: out_addr <= base, remaining <= len, wrap <= 1, stay RUN.
  - no handshake: all state holds.
- Arithmetic: increment modulo 2^WIDTH; base+len-1 beyond 2^WIDTH-1 wraps to 0 silently. len=1 circular repeats base forever with wrap every beat.
- done and wrap are never high at once; each is high exactly one cycle.

## Timing
- start sampled at edge n -> out_valid=1, out_addr=base, busy=1 after edge n.
- With out_ready held high: one new address per cycle; linear burst of L beats occupies L cycles of out_valid.
- Last handshake at edge m -> out_valid=0, busy=0, done=1 after edge m; done=0 after m+1. New start accepted at edge m+1.
- ld sampled at edge n -> out_addr=in_addr after edge n (1-cycle latency, as legacy).
- out_valid never drops and out_addr never changes while out_valid & !out_ready, except on abort or reset.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package addr_seq_pkg: state enum (IDLE, RUN), WIDTH/LEN_W defaults.
- One sub-module: addr_seq_cnt (loadable down-counter for remaining, LEN_W wide, load/decrement/is_one). Address register and FSM in the top.

## Test plan
- Reset/legacy: rst=0 two cycles -> all outputs 0; rst=1, ld=1, in_addr=0x07 -> out_addr=0x07 next cycle, out_valid=0; ld=0 -> holds 0x07.
- Linear burst: base=0x10, len=4, circ=0, out_ready=1 -> out_addr 0x10,0x11,0x12,0x13 on consecutive cycles, then done=1 one cycle, busy=0.
- Backpressure: same burst, out_ready=0 for 3 cycles at beat 0x11 -> out_addr stays 0x11, out_valid=1; resumes 0x12 after ready returns; ld=1 during RUN has no effect.
- Circular + abort: base=0xFE, len=3, circ=1 -> 0xFE,0xFF,0x00, wrap=1 with return to 0xFE; abort=1 together with a handshake -> out_valid=0 next cycle, no done, no wrap.
- Edge cases: start with len=0 -> done=1, out_valid never 1; start and ld together in IDLE -> burst starts, in_addr ignored; rst=0 mid-burst -> out_addr=0, out_valid=0, no done.
